// File: rtl/rcb_frl_msg_tx_if.sv
// Purpose: FIFO read port and byte-stream signals of the FRL message transmitter.
//  master: transmitter side (drives fifo_rden and the tx_* stream, reads FIFO status/data, tx_ready)
//  slave : FIFO / sink side (drives fifo_empty, fifo_do, tx_ready)
interface rcb_frl_msg_tx_if;
    logic        fifo_empty;
    logic [39:0] fifo_do;
    logic        fifo_rden;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;

    modport master (
        input  fifo_empty, fifo_do, tx_ready,
        output fifo_rden, tx_data, tx_valid, tx_sof, tx_eof
    );

    modport slave (
        output fifo_empty, fifo_do, tx_ready,
        input  fifo_rden, tx_data, tx_valid, tx_sof, tx_eof
    );
endinterface

// File: rtl/rcb_frl_msg_tx.sv
// Purpose: pops one 40-bit FRL message from the FIFO (standard mode, output register on)
//  and sends it as a 7-byte frame (header, 5 payload bytes MSB first, checksum) on a
//  byte-wide valid/ready stream.
// Ports:
//  clk      in   single clock (FIFO read clock and stream clock)
//  rst      in   asynchronous reset, active high
//  enable   in   allows new frames to start; a started frame always completes
//  bus      if   master side: fifo_empty/fifo_do/fifo_rden and tx_data/valid/ready/sof/eof
//  busy     out  high in every state except IDLE
//  msg_cnt  out  frames fully sent, wraps modulo 2^CNT_W
module rcb_frl_msg_tx #(
    parameter logic [7:0]  HDR_BYTE   = 8'hF5,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    rcb_frl_msg_tx_if.master     bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     msg_cnt
);
    localparam int unsigned MSG_W  = 40;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NPAY   = 5;
    localparam int unsigned WAIT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY);
    localparam logic [2:0]        IDX_LAST  = 3'(NPAY - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, HDR, PAY, CSUM} state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [MSG_W-1:0]   shift_q, shift_d;
    logic [BYTE_W-1:0]  csum_q, csum_d;
    logic               rden_q, rden_d;
    logic               valid_q, valid_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               xfer_c;

    // Inverted modulo-256 sum of the five payload bytes.
    function automatic logic [BYTE_W-1:0] csum_of(input logic [MSG_W-1:0] w);
        logic [BYTE_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < NPAY; i++) begin
            s = s + w[i*BYTE_W +: BYTE_W];
        end
        return ~s;
    endfunction

    assign xfer_c = valid_q & bus.tx_ready;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            csum_q  <= '0;
            rden_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            csum_q  <= csum_d;
            rden_q  <= rden_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and next register values; stream outputs hold unless a transfer happens.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        csum_d  = csum_q;
        rden_d  = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && !bus.fifo_empty) begin
                    rden_d  = 1'b1;
                    wcnt_d  = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // rden is high during the first RD_WAIT cycle; data is valid RD_LATENCY later.
                if (wcnt_q == WAIT_LAST) begin
                    shift_d = bus.fifo_do;
                    csum_d  = csum_of(bus.fifo_do);
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    data_d  = HDR_BYTE;
                    state_d = HDR;
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            HDR: begin
                if (xfer_c) begin
                    sof_d   = 1'b0;
                    idx_d   = '0;
                    data_d  = shift_q[MSG_W-1 -: BYTE_W];
                    state_d = PAY;
                end
            end
            PAY: begin
                if (xfer_c) begin
                    shift_d = shift_q << BYTE_W;
                    if (idx_q == IDX_LAST) begin
                        data_d  = csum_q;
                        eof_d   = 1'b1;
                        state_d = CSUM;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = shift_q[MSG_W-BYTE_W-1 -: BYTE_W];
                    end
                end
            end
            CSUM: begin
                if (xfer_c) begin
                    valid_d = 1'b0;
                    eof_d   = 1'b0;
                    data_d  = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.fifo_rden = rden_q;
    assign bus.tx_valid  = valid_q;
    assign bus.tx_data   = data_q;
    assign bus.tx_sof    = sof_q;
    assign bus.tx_eof    = eof_q;
    assign busy          = busy_q;
    assign msg_cnt       = cnt_q;
endmodule
